// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive types and oversampling constants; PARITY state exists only with UART_PARITY_EN
package uart_pkg;
  localparam int OVERSAMPLE  = 16;
  localparam int MID_SAMPLE  = 7;
  localparam int DEF_CLK_DIV = 163;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: resettable oversample tick divider, one tick every CLK_DIV clocks while clear is low
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);
  localparam int W = $clog2(CLK_DIV);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == W'(CLK_DIV - 1);
  // wrap on tick, restart from zero whenever the owner clears
  always_comb cnt_d = (clear || tick) ? '0 : cnt_q + 1'b1;
  // divider register
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 16x-oversampled UART receiver with valid/ready delivery; define UART_PARITY_EN for even parity
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
`ifdef UART_PARITY_EN
  ,
  output logic                 parity_err
`endif
);
  localparam int BW = $clog2(DATA_BITS);
`ifdef UART_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  logic [1:0]           sync_q, sync_d, warm_q, warm_d;
  logic                 rx_s, rx_s_d_q, rx_s_d_d, start_edge, tick, mid;
  state_t               state_q, state_d;
  logic [3:0]           scnt_q, scnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, rx_data_q, rx_data_d;
  logic                 done_q, done_d, stop_q, stop_d, good, load;
  logic                 rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d, busy_q, busy_d;
`ifdef UART_PARITY_EN
  logic                 perr_q, perr_d, parity_err_q, parity_err_d;
  assign good       = done_q & stop_q & ~perr_q;
  assign parity_err = parity_err_q;
`else
  assign good       = done_q & stop_q;
`endif
  assign rx_s       = sync_q[1];
  assign start_edge = rx_s_d_q & ~rx_s;
  assign mid        = scnt_q == 4'(OVERSAMPLE - 1);
  assign load       = good & (~rx_valid_q | rx_ready);
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

  baud_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(state_q == IDLE),
    .tick (tick)
  );

  // synchronizer; the edge register stays low until two real line samples have flushed the reset values
  always_comb begin
    sync_d   = {sync_q[0], rx};
    warm_d   = {warm_q[0], 1'b1};
    rx_s_d_d = warm_q[1] & rx_s;
  end

  // frame sequencer: start validation at half bit, then one mid-bit sample per bit
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    stop_d  = stop_q;
`ifdef UART_PARITY_EN
    perr_d  = perr_q;
`endif
    case (state_q)
      IDLE: if (start_edge) begin
        state_d = START;
        scnt_d  = '0;
      end
      START: if (tick) begin
        if (scnt_q == 4'(MID_SAMPLE)) begin
          state_d = rx_s ? IDLE : DATA;
          scnt_d  = '0;
          bcnt_d  = '0;
        end else scnt_d = scnt_q + 1'b1;
      end
      DATA: if (tick) begin
        scnt_d = scnt_q + 1'b1;
        if (mid) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bcnt_d  = bcnt_q + 1'b1;
          state_d = bcnt_q == BW'(DATA_BITS - 1) ? AFTER_DATA : DATA;
        end
      end
`ifdef UART_PARITY_EN
      PARITY: if (tick) begin
        scnt_d = scnt_q + 1'b1;
        if (mid) begin
          perr_d  = rx_s ^ (^shift_q);
          state_d = STOP;
        end
      end
`endif
      STOP: if (tick) begin
        scnt_d = scnt_q + 1'b1;
        if (mid) begin
          done_d  = 1'b1;
          stop_d  = rx_s;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // registered outputs: delivery, drop-on-overrun and error pulses one cycle after the stop sample
  always_comb begin
    rx_data_d    = load ? shift_q : rx_data_q;
    rx_valid_d   = load | (rx_valid_q & ~rx_ready);
    frame_err_d  = done_q & ~stop_q;
    overrun_d    = good & rx_valid_q & ~rx_ready;
    busy_d       = state_q != IDLE;
`ifdef UART_PARITY_EN
    parity_err_d = done_q & perr_q;
`endif
  end

  // all state, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q       <= 2'b11;
      warm_q       <= '0;
      rx_s_d_q     <= 1'b0;
      state_q      <= IDLE;
      scnt_q       <= '0;
      bcnt_q       <= '0;
      shift_q      <= '0;
      done_q       <= 1'b0;
      stop_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_PARITY_EN
      perr_q       <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync_q       <= sync_d;
      warm_q       <= warm_d;
      rx_s_d_q     <= rx_s_d_d;
      state_q      <= state_d;
      scnt_q       <= scnt_d;
      bcnt_q       <= bcnt_d;
      shift_q      <= shift_d;
      done_q       <= done_d;
      stop_q       <= stop_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
`ifdef UART_PARITY_EN
      perr_q       <= perr_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl with directed and random frames; follows UART_PARITY_EN
module tb_uart_rx_ctrl;
  localparam int D    = 4;
  localparam int BITC = 16 * D;
`ifdef UART_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int LAT = 152 * D + 3 + PAR * 16 * D;

  typedef enum int {E_BYTE, E_FERR, E_OVR, E_PERR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
    int         at;
  } ev_t;

  logic       clk = 1'b0, rst_n = 1'b0, rx = 1'b1, rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy, parity_err;
  int         cyc = 0, checks = 0, failures = 0, busy_rise = -1;
  ev_t        expq[$];
  bit         m_valid = 1'b0;
  logic       prev_v = 1'b0, prev_hs = 1'b0, prev_busy = 1'b0;

  uart_rx_ctrl #(.CLK_DIV(D), .DATA_BITS(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
`ifdef UART_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );
`ifndef UART_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h cycle=%0d", name, got, exp, cyc);
    end
  endfunction

  function automatic void observe(ev_kind_t k, logic [7:0] d);
    ev_t e;
    if (expq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event kind=%0d data=%0h cycle=%0d", k, d, cyc);
    end else begin
      e = expq.pop_front();
      check("event_kind", k, e.kind);
      check("event_cycle", cyc, e.at);
      if (k == E_BYTE) check("rx_data", d, e.data);
    end
  endfunction

  // monitor: every new byte or error pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && !prev_busy) busy_rise = cyc;
      if (rx_valid && (!prev_v || prev_hs)) observe(E_BYTE, rx_data);
      if (frame_err) observe(E_FERR, 8'h0);
      if (overrun) observe(E_OVR, 8'h0);
      if (parity_err) observe(E_PERR, 8'h0);
      prev_hs   = rx_valid && rx_ready;
      prev_v    = rx_valid;
      prev_busy = busy;
    end else begin
      prev_hs   = 1'b0;
      prev_v    = 1'b0;
      prev_busy = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    rx = 1'b1;
    repeat (k) step();
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    m_valid  = 1'b0;
    check("drain_clears_valid", rx_valid, 1'b0);
  endtask

  // drives one frame; the outcome is predicted from the delivery rules before the line moves
  task automatic send(input logic [7:0] d, input bit stopb, input bit parb, input bit rdy_done, output int t_done);
    bit pbad;
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (PAR != 0) bits.push_back(parb);
    bits.push_back(stopb);
    t_done = cyc + 1 + LAT;
    pbad = (PAR != 0) && (parb != ^d);
    if (stopb && !pbad) begin
      if (!m_valid || rdy_done) begin
        expq.push_back(ev_t'{kind: E_BYTE, data: d, at: t_done});
        m_valid = 1'b1;
      end else expq.push_back(ev_t'{kind: E_OVR, data: 8'h0, at: t_done});
    end else if (rdy_done) m_valid = 1'b0;
    if (!stopb) expq.push_back(ev_t'{kind: E_FERR, data: 8'h0, at: t_done});
    if (pbad) expq.push_back(ev_t'{kind: E_PERR, data: 8'h0, at: t_done});
    for (int c = 0; c < bits.size() * BITC; c++) begin
      rx = bits[c / BITC];
      rx_ready = (cyc == t_done - 1) ? rdy_done : 1'b0;
      step();
    end
    rx_ready = 1'b0;
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog expired cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, br;
    logic [7:0] d;
    bit sb, pb;
    repeat (5) step();
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    check("reset_busy", busy, 0);
    check("reset_parity_err", parity_err, 0);
    rst_n = 1'b1;
    idle(10);

    send(8'hA5, 1'b1, ^8'hA5, 1'b0, t);
    check("busy_rise_latency", busy_rise, t - LAT + 3);
    idle(50);
    check("hold_valid", rx_valid, 1'b1);
    check("hold_data", rx_data, 8'hA5);
    check("idle_busy", busy, 1'b0);
    drain();

    br = busy_rise;
    rx = 1'b0;
    repeat (20) step();
    idle(100);
    check("glitch_busy_pulsed", busy_rise > br, 1'b1);
    check("glitch_busy_low", busy, 1'b0);
    check("glitch_no_valid", rx_valid, 1'b0);

    send(8'h3C, 1'b0, ^8'h3C, 1'b0, t);
    br = busy_rise;
    rx = 1'b0;
    repeat (200) step();
    check("ferr_no_restart", busy_rise, br);
    check("ferr_no_valid", rx_valid, 1'b0);
    idle(20);

    send(8'h11, 1'b1, ^8'h11, 1'b0, t);
    send(8'h22, 1'b1, ^8'h22, 1'b0, t);
    check("overrun_keeps_old", rx_data, 8'h11);
    send(8'h33, 1'b1, ^8'h33, 1'b1, t);
    check("handshake_reload", rx_data, 8'h33);
    drain();
    idle(10);

    rx = 1'b0;
    repeat (BITC) step();
    for (int i = 0; i < 3; i++) begin
      rx = d_bit(8'h5A, i);
      repeat (BITC) step();
    end
    rx = 1'b0;
    rst_n = 1'b0;
    repeat (4) step();
    expq.delete();
    m_valid = 1'b0;
    rst_n = 1'b1;
    step();
    br = busy_rise;
    repeat (60) step();
    check("rst_abort_valid", rx_valid, 1'b0);
    check("rst_abort_data", rx_data, 8'h00);
    check("rst_abort_busy", busy, 1'b0);
    check("rst_low_line_no_start", busy_rise, br);
    idle(20);
    send(8'h5A, 1'b1, ^8'h5A, 1'b0, t);
    idle(5);
    check("after_reset_data", rx_data, 8'h5A);
    drain();

`ifdef UART_PARITY_EN
    send(8'h07, 1'b1, 1'b0, 1'b0, t);
    idle(5);
    check("parity_bad_no_valid", rx_valid, 1'b0);
    send(8'h07, 1'b1, 1'b1, 1'b0, t);
    idle(5);
    check("parity_good_data", rx_data, 8'h07);
    drain();
`endif

    for (int n = 0; n < 24; n++) begin
      d  = 8'($urandom);
      sb = $urandom_range(0, 5) != 0;
      pb = (PAR != 0 && $urandom_range(0, 4) == 0) ? ~^d : ^d;
      send(d, sb, pb, 1'($urandom_range(0, 1)), t);
      idle(sb ? $urandom_range(0, 15) : $urandom_range(2, 20));
      if ($urandom_range(0, 2) == 0) drain();
    end

    idle(20);
    check("scoreboard_empty", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic d_bit(input logic [7:0] v, input int i);
    return v[i];
  endfunction
endmodule
